led_shift_sequencer: RTL and testbench
======================================

// Module: led_shift_sequencer
// PURPOSE
//  Controller for the board's LED shift-register datapath. Turns raw key inputs
//  into debounced commands (mode/run/clear), runs a start/pause/clear FSM, and
//  advances the W-bit LED pattern by one step per divided-clock tick.
//  Sits between the key pins and the led port of the board top.
// PARAMETERS
//  W              8   LED pattern width (>=2)
//  TICK_DIV_LOG2  23  step period = 2**TICK_DIV_LOG2 clk cycles
//  DEBOUNCE_LOG2  16  key must be stable 2**DEBOUNCE_LOG2 cycles to register
// PORTS
//  clk        in   1  clock
//  rst        in   1  synchronous reset, active-high
//  btn_mode   in   1  raw key, active-high, async; press cycles mode
//  btn_run    in   1  raw key; press starts/pauses/resumes
//  btn_clear  in   1  raw key; press returns to IDLE
//  btn_speed  in   1  raw key; used only with LED_SEQ_SPEED_CTRL_EN
//  led        out  W  pattern, active-high, registered (top inverts for board)
//  busy       out  1  1 while state==RUN
//  mode       out  2  current mode_t
// BEHAVIOUR
//  Reset: led=0, busy=0, mode=SHIFT_R, state=IDLE, tick counter=0, fill=1, dir=right.
//  Keys: 2-FF sync; debounced level changes after input stable 2**DEBOUNCE_LOG2 cycles;
//   rising edge of debounced level = 1-cycle press pulse. Shorter glitches ignored.
//  Tick: counter cleared on entering RUN; held in PAUSE; tick on cycle counter==all-ones,
//   so first step occurs 2**TICK_DIV_LOG2 cycles after entering RUN.
//  FSM: IDLE -run-> LOAD (1 cycle, seed pattern) -> RUN; RUN -run-> PAUSE;
//   PAUSE -run-> RUN, or -> LOAD if mode changed while paused (reload flag);
//   clear in any state -> IDLE, led=0, fill=1, dir=right. Mode retained over clear.
//  Mode press: mode=(mode+1) mod 4; accepted in IDLE/PAUSE only, ignored in LOAD/RUN.
//  Priority in same cycle: clear > mode > run. IDLE mode+run: LOAD uses new mode.
//  Seeds: SHIFT_R/SHIFT_L -> 0 with fill=1; ROTATE -> MSB only; BOUNCE -> MSB, dir=right.
//  Step on tick:
//   SHIFT_R: p={fill,p[W-1:1]}; SHIFT_L: p={p[W-2:0],fill};
//    fill toggles when new p is all-ones or all-zeros (fill/drain loop).
//   ROTATE: rotate right by 1, wraps bit0->bit W-1.
//   BOUNCE: single bit moves per dir; reaching bit0 sets dir=left, bit W-1 sets right;
//    end positions shown for one tick.
//  led updates 1 cycle after the state/pattern register; busy follows state.
//  rst mid-operation overrides everything at the next edge.
// CONFIGURATION
//  LED_SEQ_SPEED_CTRL_EN defined: btn_speed press cycles sel 0..3 (reset 0);
//   period = 2**(TICK_DIV_LOG2-sel); sel change clears tick counter; needs TICK_DIV_LOG2>=4.
//  Undefined: btn_speed ignored (port kept), period fixed 2**TICK_DIV_LOG2.
// STRUCTURE
//  Package led_seq_pkg: mode_t {MODE_SHIFT_R=0,MODE_SHIFT_L,MODE_ROTATE,MODE_BOUNCE},
//   state_t {ST_IDLE,ST_LOAD,ST_RUN,ST_PAUSE}, MODE_W=2.
//  Sub-module button_conditioner (sync + debounce + press pulse), DEBOUNCE_LOG2
//   parameter, instanced once per key; FSM, tick counter, pattern datapath in top level.
// TESTING (W=8, TICK_DIV_LOG2=3, DEBOUNCE_LOG2=2)
//  1 Reset held 5 cycles -> led=00, busy=0, mode=0; stays so with no keys.
//  2 run press, SHIFT_R -> busy=1; every 8 cycles led 80,C0,..,FF,7F,..,01,00,80.
//  3 mode x3 in IDLE -> mode=3; run -> led 80,40,..,01,02,..,80 (bounce).
//  4 RUN, run press -> busy=0, led frozen 100 cycles; run -> resumes same count/pattern.
//  5 clear+run same cycle in RUN -> IDLE, led=00; mode press in RUN -> mode unchanged.
//  6 3-cycle key glitch -> no effect; with LED_SEQ_SPEED_CTRL_EN, speed press -> period 4.

Source files
------------

// File: rtl/led_seq_pkg.sv
// ---------------------------------------------------------------------------
// led_seq_pkg: shared types for the LED shift sequencer.   Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package led_seq_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_SHIFT_R = 2'd0,
    MODE_SHIFT_L = 2'd1,
    MODE_ROTATE  = 2'd2,
    MODE_BOUNCE  = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_RUN   = 2'd2,
    ST_PAUSE = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/led_shift_sequencer_button.sv
// ---------------------------------------------------------------------------
// button_conditioner: 2-FF sync, debounce, one-cycle press pulse.   Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module button_conditioner #(
  parameter int DEBOUNCE_LOG2 = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic press
);

  logic [1:0]               sync;
  logic                     level;
  logic [DEBOUNCE_LOG2-1:0] stable_cnt;

  // The level only follows the synchronized key after it has disagreed for
  // 2**DEBOUNCE_LOG2 consecutive cycles; any return to the old level restarts.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync       <= 2'b00;
      level      <= 1'b0;
      stable_cnt <= '0;
      press      <= 1'b0;
    end else begin
      sync  <= {sync[0], raw};
      press <= 1'b0;
      if (sync[1] == level) begin
        stable_cnt <= '0;
      end else if (&stable_cnt) begin
        level      <= sync[1];
        stable_cnt <= '0;
        press      <= sync[1];
      end else begin
        stable_cnt <= stable_cnt + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/led_shift_sequencer.sv
// ---------------------------------------------------------------------------
// led_shift_sequencer: key-driven start/pause/clear LED pattern sequencer.
// Optional feature macro: LED_SEQ_SPEED_CTRL_EN (speed key).   Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module led_shift_sequencer
  import led_seq_pkg::*;
#(
  parameter int W             = 8,
  parameter int TICK_DIV_LOG2 = 23,
  parameter int DEBOUNCE_LOG2 = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              btn_mode,
  input  logic              btn_run,
  input  logic              btn_clear,
  input  logic              btn_speed,
  output logic [W-1:0]      led,
  output logic              busy,
  output logic [MODE_W-1:0] mode
);

  localparam logic [W-1:0]             MSB_ONLY = {1'b1, {(W-1){1'b0}}};
  localparam logic [TICK_DIV_LOG2-1:0] TICK_ALL = '1;

  logic mode_press, run_press, clear_press, speed_clr;
  logic mode_accept, load_en, run_en, tick;
  logic reload, fill, dir_left;
  logic step_fill, step_dir_left;
  logic [W-1:0]             pattern, step_pat;
  logic [TICK_DIV_LOG2-1:0] tick_cnt, tick_mask;
  state_t state, state_next;
  mode_t  cur_mode;

  button_conditioner #(.DEBOUNCE_LOG2(DEBOUNCE_LOG2)) u_btn_mode (
    .clk(clk), .rst(rst), .raw(btn_mode), .press(mode_press));
  button_conditioner #(.DEBOUNCE_LOG2(DEBOUNCE_LOG2)) u_btn_run (
    .clk(clk), .rst(rst), .raw(btn_run), .press(run_press));
  button_conditioner #(.DEBOUNCE_LOG2(DEBOUNCE_LOG2)) u_btn_clear (
    .clk(clk), .rst(rst), .raw(btn_clear), .press(clear_press));

`ifdef LED_SEQ_SPEED_CTRL_EN
  logic       speed_press;
  logic [1:0] speed_sel;

  button_conditioner #(.DEBOUNCE_LOG2(DEBOUNCE_LOG2)) u_btn_speed (
    .clk(clk), .rst(rst), .raw(btn_speed), .press(speed_press));

  always_ff @(posedge clk) begin
    if (rst) speed_sel <= 2'd0;
    else if (speed_press) speed_sel <= speed_sel + 2'd1;
  end

  assign speed_clr = speed_press;
  assign tick_mask = TICK_ALL >> speed_sel;
`else
  logic unused_speed;
  assign unused_speed = btn_speed;
  assign speed_clr    = 1'b0;
  assign tick_mask    = TICK_ALL;
`endif

  assign mode_accept = mode_press && !clear_press &&
                       (state == ST_IDLE || state == ST_PAUSE);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (clear_press) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  if (run_press) state_next = ST_LOAD;
        ST_LOAD:  state_next = ST_RUN;
        ST_RUN:   if (run_press) state_next = ST_PAUSE;
        ST_PAUSE: if (run_press) state_next = (reload || mode_accept) ? ST_LOAD : ST_RUN;
        default:  state_next = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    busy    = (state == ST_RUN);
    load_en = (state == ST_LOAD);
    run_en  = (state == ST_RUN);
  end

  // Low bits of the free counter set the period, so a speed change only
  // narrows the compare window rather than reloading a divider.
  assign tick = run_en && ((tick_cnt | ~tick_mask) == TICK_ALL);

  always_comb begin
    step_pat      = pattern;
    step_fill     = fill;
    step_dir_left = dir_left;
    case (cur_mode)
      MODE_SHIFT_R: step_pat = {fill, pattern[W-1:1]};
      MODE_SHIFT_L: step_pat = {pattern[W-2:0], fill};
      MODE_ROTATE:  step_pat = {pattern[0], pattern[W-1:1]};
      default: begin
        if (dir_left) begin
          step_pat = {pattern[W-2:0], 1'b0};
          if (step_pat[W-1]) step_dir_left = 1'b0;
        end else begin
          step_pat = {1'b0, pattern[W-1:1]};
          if (step_pat[0]) step_dir_left = 1'b1;
        end
      end
    endcase
    if ((cur_mode == MODE_SHIFT_R || cur_mode == MODE_SHIFT_L) &&
        (step_pat == '0 || &step_pat))
      step_fill = ~fill;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pattern  <= '0;
      fill     <= 1'b1;
      dir_left <= 1'b0;
      cur_mode <= MODE_SHIFT_R;
      reload   <= 1'b0;
      tick_cnt <= '0;
      led      <= '0;
    end else begin
      led <= pattern;

      if (mode_accept) cur_mode <= mode_t'(cur_mode + 2'd1);

      if (clear_press || load_en)                reload <= 1'b0;
      else if (mode_accept && state == ST_PAUSE) reload <= 1'b1;

      if (speed_clr || state == ST_IDLE || load_en) tick_cnt <= '0;
      else if (run_en)                               tick_cnt <= tick_cnt + 1'b1;

      if (clear_press) begin
        pattern  <= '0;
        fill     <= 1'b1;
        dir_left <= 1'b0;
      end else if (load_en) begin
        pattern  <= (cur_mode == MODE_SHIFT_R || cur_mode == MODE_SHIFT_L) ? '0 : MSB_ONLY;
        fill     <= 1'b1;
        dir_left <= 1'b0;
      end else if (tick) begin
        pattern  <= step_pat;
        fill     <= step_fill;
        dir_left <= step_dir_left;
      end
    end
  end

  assign mode = cur_mode;

endmodule

`default_nettype wire

// File: tb/tb_led_shift_sequencer.sv
// ---------------------------------------------------------------------------
// tb_led_shift_sequencer: directed scoreboard bench for led_shift_sequencer.
// ---------------------------------------------------------------------------
`default_nettype none

module tb_led_shift_sequencer;

  localparam logic [3:0] K_MODE = 4'b0001;
  localparam logic [3:0] K_RUN  = 4'b0010;
  localparam logic [3:0] K_CLR  = 4'b0100;
  localparam logic [3:0] K_SPD  = 4'b1000;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_mode, btn_run, btn_clear, btn_speed;
  logic [7:0] led;
  logic       busy;
  logic [1:0] mode;

  int vectors = 0;
  int fails   = 0;
  int cyc     = 0;

  logic [7:0] exp_q[$];
  int         chg_q[$];
  logic       track = 1'b0;
  logic [7:0] last_led = 8'h00, prev_led = 8'h00;
  logic       last_busy = 1'b0;
  int         chg_count = 0, last_chg_cyc = 0, rise_cyc = 0, fall_cyc = 0;

  led_shift_sequencer #(.W(8), .TICK_DIV_LOG2(3), .DEBOUNCE_LOG2(2)) dut (
    .clk(clk), .rst(rst), .btn_mode(btn_mode), .btn_run(btn_run),
    .btn_clear(btn_clear), .btn_speed(btn_speed),
    .led(led), .busy(busy), .mode(mode));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every LED change is logged; while tracking it is popped and compared.
  always @(negedge clk) begin
    if (!rst) begin
      if (led !== last_led) begin
        if (track) begin
          check("led_expected_pending", (exp_q.size() > 0), 1);
          if (exp_q.size() > 0) check("led_step", led, exp_q.pop_front());
        end
        prev_led     = last_led;
        last_led     = led;
        last_chg_cyc = cyc;
        chg_count++;
        chg_q.push_back(cyc);
      end
      if (busy === 1'b1 && last_busy === 1'b0) rise_cyc = cyc;
      if (busy === 1'b0 && last_busy === 1'b1) fall_cyc = cyc;
      last_busy = busy;
    end
  end

  function automatic logic [7:0] next_bounce(input logic [7:0] cur, input logic [7:0] prv);
    if (cur == 8'h01) return 8'h02;
    if (cur == 8'h80) return 8'h40;
    if (prv > cur) return cur >> 1;
    return cur << 1;
  endfunction

  task automatic drive(input logic [3:0] m);
    {btn_speed, btn_clear, btn_run, btn_mode} = m;
  endtask

  task automatic press(input logic [3:0] m);
    @(negedge clk); drive(m);
    repeat (10) @(negedge clk);
    drive(4'b0000);
    repeat (10) @(negedge clk);
    #1;
  endtask

  task automatic glitch(input logic [3:0] m);
    @(negedge clk); drive(m);
    repeat (3) @(negedge clk);
    drive(4'b0000);
    repeat (10) @(negedge clk);
    #1;
  endtask

  task automatic wait_changes(input string tag, input int target, input int budget);
    int n = 0;
    while (chg_count < target && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    check(tag, (chg_count >= target), 1);
  endtask

  initial begin
    int base, c, bad;
    logic [7:0] frozen, cur, prv, nxt;

    rst = 1'b1;
    drive(4'b0000);
    repeat (5) @(posedge clk);
    @(negedge clk); #1;
    check("rst_led", led, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_mode", mode, 2'd0);
    rst = 1'b0;
    repeat (20) @(negedge clk); #1;
    check("idle_led", led, 8'h00);
    check("idle_busy", busy, 1'b0);

    // SHIFT_R fill then drain, one step every 8 cycles
    exp_q.delete(); chg_q.delete();
    for (int i = 1; i <= 8; i++) exp_q.push_back(8'hFF << (8 - i));
    for (int i = 1; i <= 8; i++) exp_q.push_back(8'hFF >> i);
    exp_q.push_back(8'h80);
    track = 1'b1; base = chg_count;
    press(K_RUN);
    wait_changes("shr_changes", base + 17, 300);
    track = 1'b0;
    check("shr_busy", busy, 1'b1);
    check("shr_queue_empty", exp_q.size(), 0);
    if (chg_q.size() >= 17) begin
      check("shr_first_latency", chg_q[0] - rise_cyc, 9);
      bad = 0;
      for (int i = 1; i < 17; i++) if (chg_q[i] - chg_q[i-1] != 8) bad++;
      check("shr_period", bad, 0);
    end
    press(K_CLR);
    check("clr_led", led, 8'h00);
    check("clr_busy", busy, 1'b0);

    // Bounce
    press(K_MODE); press(K_MODE); press(K_MODE);
    check("mode_x3", mode, 2'd3);
    exp_q.delete();
    for (int i = 0; i < 8; i++) exp_q.push_back(8'h80 >> i);
    for (int i = 1; i < 8; i++) exp_q.push_back(8'h01 << i);
    exp_q.push_back(8'h40);
    track = 1'b1; base = chg_count;
    press(K_RUN);
    wait_changes("bounce_changes", base + 16, 300);
    track = 1'b0;
    check("bounce_queue_empty", exp_q.size(), 0);

    // Pause: frozen output, resume continues the same count and pattern
    press(K_RUN);
    check("pause_busy", busy, 1'b0);
    c = (fall_cyc - last_chg_cyc + 1) % 8;
    frozen = led; base = chg_count;
    repeat (100) @(negedge clk); #1;
    check("pause_led_frozen", led, frozen);
    check("pause_no_changes", chg_count, base);
    exp_q.delete(); chg_q.delete();
    cur = last_led; prv = prev_led;
    for (int i = 0; i < 6; i++) begin
      nxt = next_bounce(cur, prv);
      exp_q.push_back(nxt);
      prv = cur; cur = nxt;
    end
    track = 1'b1;
    press(K_RUN);
    wait_changes("resume_change", base + 1, 50);
    track = 1'b0;
    if (chg_q.size() >= 1) check("resume_latency", chg_q[0] - rise_cyc, 9 - c);

    // Mode ignored in RUN; clear beats run in the same cycle
    press(K_MODE);
    check("mode_in_run", mode, 2'd3);
    check("still_busy", busy, 1'b1);
    press(K_CLR | K_RUN);
    check("clrrun_busy", busy, 1'b0);
    check("clrrun_led", led, 8'h00);
    check("clrrun_mode_kept", mode, 2'd3);
    repeat (20) @(negedge clk); #1;
    check("clrrun_stays_idle", busy, 1'b0);
    press(K_MODE);
    check("mode_wrap", mode, 2'd0);

    // Mode change while paused forces a reload with the new mode
    exp_q.delete();
    exp_q.push_back(8'h80); exp_q.push_back(8'hC0); exp_q.push_back(8'hE0);
    track = 1'b1; base = chg_count;
    press(K_RUN);
    wait_changes("reload_pre", base + 3, 100);
    track = 1'b0;
    press(K_RUN);
    press(K_MODE);
    check("pause_mode", mode, 2'd1);
    exp_q.delete();
    exp_q.push_back(8'h00); exp_q.push_back(8'h01); exp_q.push_back(8'h03);
    track = 1'b1; base = chg_count;
    press(K_RUN);
    wait_changes("reload_post", base + 3, 100);
    track = 1'b0;
    check("reload_queue_empty", exp_q.size(), 0);

    // Short glitches are rejected
    press(K_CLR);
    glitch(K_RUN);
    glitch(K_MODE);
    repeat (20) @(negedge clk); #1;
    check("glitch_busy", busy, 1'b0);
    check("glitch_mode", mode, 2'd1);
    check("glitch_led", led, 8'h00);

`ifdef LED_SEQ_SPEED_CTRL_EN
    press(K_SPD);
    exp_q.delete(); chg_q.delete();
    exp_q.push_back(8'h01); exp_q.push_back(8'h03); exp_q.push_back(8'h07);
    track = 1'b1; base = chg_count;
    press(K_RUN);
    wait_changes("speed_changes", base + 3, 100);
    track = 1'b0;
    if (chg_q.size() >= 2) begin
      check("speed_first_latency", chg_q[0] - rise_cyc, 5);
      check("speed_period", chg_q[1] - chg_q[0], 4);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule

`default_nettype wire
